// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: operation codes, FSM states, flag bit positions.
package alu_pkg;

   // SELOP operation codes understood by the shared ALU
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_AND  = 4'b0111;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_SLTU = 4'b0010;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Bit positions inside the 4-bit response flags {error, negative, zero, carry}
   localparam int FLAG_C   = 0;
   localparam int FLAG_Z   = 1;
   localparam int FLAG_NEG = 2;
   localparam int FLAG_ERR = 3;

   // True when the code is one the ALU implements
   function automatic logic op_is_legal(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
         OP_SLL, OP_SRL, OP_SRA, OP_SLTU: op_is_legal = 1'b1;
         default:                         op_is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant. A lone requester wins outright; on a tie the
// port that did not win last time is granted. The winner is remembered only
// when the caller signals that the grant was actually consumed.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_update,
   output logic [1:0] o_grant
);

   logic r_last_grant;

   // Combinational one-hot grant
   always_comb begin
      o_grant = 2'b00;
      case (i_req)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
         default: o_grant = 2'b00;
      endcase
   end

   // Last winner; reset to port 1 so port 0 takes the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
      end else if (i_update) begin
         r_last_grant <= o_grant[1];
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// address/auxiliary unit (port 1). Operands are registered into the ALU,
// the result is captured one cycle later and returned to the owner.
//
// Handshake: on every channel a transfer happens at the rising edge where
// valid and ready are both 1. Requesters keep valid/payload stable until
// ready; responses keep valid/result/flags stable until ready.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int ANCHO = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [ANCHO-1:0] req0_a,
   input  logic [ANCHO-1:0] req0_b,
   input  logic [3:0]       req0_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [ANCHO-1:0] rsp0_result,
   output logic [3:0]       rsp0_flags,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [ANCHO-1:0] req1_a,
   input  logic [ANCHO-1:0] req1_b,
   input  logic [3:0]       req1_op,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [ANCHO-1:0] rsp1_result,
   output logic [3:0]       rsp1_flags,
   output logic [ANCHO-1:0] alu_a,
   output logic [ANCHO-1:0] alu_b,
   output logic [3:0]       alu_selop,
   input  logic [ANCHO-1:0] alu_result,
   input  logic             alu_flagC,
   input  logic             alu_flagZ,
   input  logic             alu_flagNeg
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       w_req;
   logic [1:0]       w_grant;
   logic             w_accept;
   logic             w_rsp_done;
   logic             w_ready0;
   logic             w_ready1;
   logic             r_owner;
   logic [ANCHO-1:0] r_alu_a;
   logic [ANCHO-1:0] r_alu_b;
   logic [3:0]       r_alu_selop;
   logic             r_rsp0_valid;
   logic             r_rsp1_valid;
   logic [ANCHO-1:0] r_rsp0_result;
   logic [ANCHO-1:0] r_rsp1_result;
   logic [3:0]       r_rsp0_flags;
   logic [3:0]       r_rsp1_flags;
   logic             w_err;
   logic [ANCHO-1:0] w_cap_result;
   logic [3:0]       w_cap_flags;

   assign w_req = {req1_valid, req0_valid};

   rr_arbiter2 u_rr (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (w_req),
      .i_update (w_accept),
      .o_grant  (w_grant)
   );

   // Next state and request-side ready; ready is gated by reset so it reads 0 while held
   always_comb begin
      w_state_nxt = r_state;
      w_ready0    = 1'b0;
      w_ready1    = 1'b0;
      w_accept    = 1'b0;
      w_rsp_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready0 = w_grant[0] & rst_n;
            w_ready1 = w_grant[1] & rst_n;
            w_accept = |w_grant;
            if (w_accept) w_state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            w_rsp_done = r_owner ? rsp1_ready : rsp0_ready;
            if (w_rsp_done) w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Illegal codes override whatever the ALU produced
   assign w_err        = ~op_is_legal(r_alu_selop);
   assign w_cap_result = w_err ? '0 : alu_result;

   // Flags as they will be handed back to the owner
   always_comb begin
      w_cap_flags           = 4'b0000;
      w_cap_flags[FLAG_ERR] = w_err;
      w_cap_flags[FLAG_NEG] = ~w_err & alu_flagNeg;
      w_cap_flags[FLAG_Z]   = w_err | alu_flagZ;
      w_cap_flags[FLAG_C]   = ~w_err & alu_flagC;
   end

   // Operand latch on acceptance, result capture in EXEC, valid clear on response handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner       <= 1'b0;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_selop   <= 4'b0000;
         r_rsp0_valid  <= 1'b0;
         r_rsp1_valid  <= 1'b0;
         r_rsp0_result <= '0;
         r_rsp1_result <= '0;
         r_rsp0_flags  <= 4'b0000;
         r_rsp1_flags  <= 4'b0000;
      end else begin
         if (w_accept) begin
            r_owner     <= w_grant[1];
            r_alu_a     <= w_grant[1] ? req1_a  : req0_a;
            r_alu_b     <= w_grant[1] ? req1_b  : req0_b;
            r_alu_selop <= w_grant[1] ? req1_op : req0_op;
         end
         if (r_state == ST_EXEC) begin
            if (r_owner) begin
               r_rsp1_result <= w_cap_result;
               r_rsp1_flags  <= w_cap_flags;
               r_rsp1_valid  <= 1'b1;
            end else begin
               r_rsp0_result <= w_cap_result;
               r_rsp0_flags  <= w_cap_flags;
               r_rsp0_valid  <= 1'b1;
            end
         end
         if (w_rsp_done) begin
            if (r_owner) r_rsp1_valid <= 1'b0;
            else         r_rsp0_valid <= 1'b0;
         end
      end
   end

   assign req0_ready  = w_ready0;
   assign req1_ready  = w_ready1;
   assign rsp0_valid  = r_rsp0_valid;
   assign rsp1_valid  = r_rsp1_valid;
   assign rsp0_result = r_rsp0_result;
   assign rsp1_result = r_rsp1_result;
   assign rsp0_flags  = r_rsp0_flags;
   assign rsp1_flags  = r_rsp1_flags;
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_selop   = r_alu_selop;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stand-in ALU, queue-fed requesters, a transaction
// model of the arbiter checked every cycle, and literal expectations per scenario.
module tb_alu_arbiter;

   localparam int W = 32;

   typedef struct {
      int         port;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0] op;
   } req_t;

   typedef struct {
      int         port;
      logic [W-1:0] res;
      logic [3:0] flg;
      int         cyc;
   } ev_t;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT wiring ----------------
   logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready;
   logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
   logic [3:0]   req0_op, req1_op, rsp0_flags, rsp1_flags;
   logic [W-1:0] alu_a, alu_b, alu_result;
   logic [3:0]   alu_selop;
   logic         alu_flagC, alu_flagZ, alu_flagNeg;

   alu_arbiter #(.ANCHO(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_selop(alu_selop),
      .alu_result(alu_result), .alu_flagC(alu_flagC), .alu_flagZ(alu_flagZ), .alu_flagNeg(alu_flagNeg)
   );

   // ---------------- ALU behaviour (stand-in and reference) ----------------
   // Returns {carry, result}. Unknown codes produce junk so that forcing is visible.
   function automatic logic [W:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         4'b0000: ref_alu = {1'b0, a} + {1'b0, b};
         4'b1000: ref_alu = {(a >= b), a - b};
         4'b0111: ref_alu = {1'b0, a & b};
         4'b0110: ref_alu = {1'b0, a | b};
         4'b0100: ref_alu = {1'b0, a ^ b};
         4'b0001: ref_alu = {1'b0, a << sh};
         4'b0101: ref_alu = {1'b0, a >> sh};
         4'b1101: ref_alu = {1'b0, W'($signed(a) >>> sh)};
         4'b0010: ref_alu = {1'b0, W'(a < b)};
         default: ref_alu = {1'b1, 32'hDEAD_BEEF};
      endcase
   endfunction

   function automatic logic legal(input logic [3:0] op);
      legal = (op == 4'b0000) || (op == 4'b1000) || (op == 4'b0111) || (op == 4'b0110) ||
              (op == 4'b0100) || (op == 4'b0001) || (op == 4'b0101) || (op == 4'b1101) ||
              (op == 4'b0010);
   endfunction

   logic [W:0] alu_out;
   assign alu_out     = ref_alu(alu_a, alu_b, alu_selop);
   assign alu_result  = alu_out[W-1:0];
   assign alu_flagC   = alu_out[W];
   assign alu_flagZ   = (alu_out[W-1:0] == '0);
   assign alu_flagNeg = alu_out[W-1];

   // ---------------- scoreboard state ----------------
   int   n_pass = 0;
   int   n_chk  = 0;
   req_t req_q[$];
   ev_t  gl[$];     // acceptances
   ev_t  rl[$];     // delivered responses

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // ---------------- requester drivers ----------------
   logic         dv[2]  = '{1'b0, 1'b0};
   logic [W-1:0] da[2]  = '{'0, '0};
   logic [W-1:0] db[2]  = '{'0, '0};
   logic [3:0]   dop[2] = '{4'b0, 4'b0};
   logic         acc[2] = '{1'b0, 1'b0};
   int           rsp_mode[2] = '{0, 0};   // 0 always ready, 1 random, 2 held low
   bit           gap_en = 1'b0;
   bit           wd_en  = 1'b0;

   assign req0_valid = dv[0];
   assign req0_a     = da[0];
   assign req0_b     = db[0];
   assign req0_op    = dop[0];
   assign req1_valid = dv[1];
   assign req1_a     = da[1];
   assign req1_b     = db[1];
   assign req1_op    = dop[1];

   function automatic int first_of(input int p);
      first_of = -1;
      for (int i = 0; i < req_q.size(); i++) begin
         if (req_q[i].port == p) begin
            first_of = i;
            break;
         end
      end
   endfunction

   task automatic push(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
      req_t r;
      r.port = p; r.a = a; r.b = b; r.op = op;
      req_q.push_back(r);
   endtask

   initial begin
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
   end

   // Present queued requests, retire them on acceptance, optionally withdraw
   always @(posedge clk) begin
      #1;
      for (int p = 0; p < 2; p++) begin
         int idx;
         if (!rst_n) begin
            dv[p] = 1'b0;
         end else begin
            if (dv[p] && acc[p]) begin
               idx = first_of(p);
               if (idx >= 0) req_q.delete(idx);
               dv[p] = 1'b0;
            end else if (dv[p] && wd_en && $urandom_range(0, 7) == 0) begin
               dv[p] = 1'b0;
            end
            if (!dv[p] && (!gap_en || $urandom_range(0, 2) == 0)) begin
               idx = first_of(p);
               if (idx >= 0) begin
                  da[p]  = req_q[idx].a;
                  db[p]  = req_q[idx].b;
                  dop[p] = req_q[idx].op;
                  dv[p]  = 1'b1;
               end
            end
         end
      end
      rsp0_ready = (rsp_mode[0] == 0) ? 1'b1 : (rsp_mode[0] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      rsp1_ready = (rsp_mode[1] == 0) ? 1'b1 : (rsp_mode[1] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   // ---------------- transaction model ----------------
   // m_st: 0 = free, 1 = operation accepted and computing, 2 = result waiting for the owner
   int           m_st    = 0;
   int           m_last  = 1;
   int           m_owner = 0;
   logic [W-1:0] m_a     = '0;
   logic [W-1:0] m_b     = '0;
   logic [3:0]   m_op    = 4'b0;
   logic [W-1:0] m_res[2] = '{'0, '0};
   logic [3:0]   m_flg[2] = '{4'b0, 4'b0};
   logic         m_rv[2]  = '{1'b0, 1'b0};

   // Which port the arbitration rules select right now (-1 for none)
   function automatic int pick();
      if (req0_valid && req1_valid) pick = (m_last == 0) ? 1 : 0;
      else if (req0_valid)          pick = 0;
      else if (req1_valid)          pick = 1;
      else                          pick = -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int         pk;
      logic [W:0] r;
      if (!rst_n) begin
         m_st = 0; m_last = 1; m_owner = 0;
         m_a = '0; m_b = '0; m_op = 4'b0;
         m_res[0] = '0; m_res[1] = '0; m_flg[0] = 4'b0; m_flg[1] = 4'b0;
         m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      end else begin
         case (m_st)
            0: begin
               pk = pick();
               if (pk >= 0) begin
                  m_owner = pk;
                  m_last  = pk;
                  m_a  = (pk == 1) ? req1_a  : req0_a;
                  m_b  = (pk == 1) ? req1_b  : req0_b;
                  m_op = (pk == 1) ? req1_op : req0_op;
                  m_st = 1;
               end
            end
            1: begin
               r = ref_alu(m_a, m_b, m_op);
               if (!legal(m_op)) begin
                  m_res[m_owner] = '0;
                  m_flg[m_owner] = 4'b1010;
               end else begin
                  m_res[m_owner] = r[W-1:0];
                  m_flg[m_owner] = {1'b0, r[W-1], (r[W-1:0] == '0), r[W]};
               end
               m_rv[m_owner] = 1'b1;
               m_st = 2;
            end
            default: begin
               if ((m_owner == 0 && rsp0_ready) || (m_owner == 1 && rsp1_ready)) begin
                  m_rv[m_owner] = 1'b0;
                  m_st = 0;
               end
            end
         endcase
      end
   end

   // ---------------- per-cycle compare and event logging ----------------
   always @(negedge clk) begin
      int   pk;
      logic e_r0, e_r1;
      ev_t  e;
      pk   = pick();
      e_r0 = rst_n && (m_st == 0) && (pk == 0);
      e_r1 = rst_n && (m_st == 0) && (pk == 1);
      acc[0] = req0_valid && req0_ready;
      acc[1] = req1_valid && req1_ready;
      chk("req0_ready",  req0_ready,  e_r0);
      chk("req1_ready",  req1_ready,  e_r1);
      chk("rsp0_valid",  rsp0_valid,  m_rv[0]);
      chk("rsp1_valid",  rsp1_valid,  m_rv[1]);
      chk("rsp0_result", rsp0_result, m_res[0]);
      chk("rsp1_result", rsp1_result, m_res[1]);
      chk("rsp0_flags",  rsp0_flags,  m_flg[0]);
      chk("rsp1_flags",  rsp1_flags,  m_flg[1]);
      chk("alu_a",       alu_a,       m_a);
      chk("alu_b",       alu_b,       m_b);
      chk("alu_selop",   alu_selop,   m_op);
      if (rst_n) begin
         e.cyc = cyc; e.res = '0; e.flg = 4'b0;
         if (acc[0]) begin e.port = 0; gl.push_back(e); end
         if (acc[1]) begin e.port = 1; gl.push_back(e); end
         if (rsp0_valid && rsp0_ready) begin e.port = 0; e.res = rsp0_result; e.flg = rsp0_flags; rl.push_back(e); end
         if (rsp1_valid && rsp1_ready) begin e.port = 1; e.res = rsp1_result; e.flg = rsp1_flags; rl.push_back(e); end
      end
   end

   // ---------------- sequencing helpers ----------------
   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      req_q.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      gl.delete();
      rl.delete();
   endtask

   task automatic wait_idle(input int max_cyc);
      bit done;
      done = 1'b0;
      for (int k = 0; k < max_cyc; k++) begin
         @(posedge clk); #2;
         if (req_q.size() == 0 && !dv[0] && !dv[1] && m_st == 0) begin
            done = 1'b1;
            break;
         end
      end
      chk("wait_idle_bound", done, 1'b1);
   endtask

   task automatic wait_rsp0(input int max_cyc);
      for (int k = 0; k < max_cyc && !rsp0_valid; k++) @(negedge clk);
      chk("rsp0_valid_seen", rsp0_valid, 1'b1);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      @(negedge clk);
      chk("reset_req0_ready", req0_ready, 1'b0);
      chk("reset_rsp0_valid", rsp0_valid, 1'b0);
      chk("reset_alu_a", alu_a, 32'd0);
      do_reset();

      // single request: 5 + 3
      push(0, 32'd5, 32'd3, 4'b0000);
      wait_idle(50);
      chk("single_n_rsp", rl.size(), 1);
      if (rl.size() >= 1 && gl.size() >= 1) begin
         chk("single_port",    rl[0].port, 0);
         chk("single_result",  rl[0].res, 32'd8);
         chk("single_flags",   rl[0].flg, 4'b0000);
         chk("single_latency", rl[0].cyc - gl[0].cyc, 2);
      end

      // tie straight after reset: port 0 first
      do_reset();
      push(0, 32'd10, 32'd20, 4'b0000);
      push(1, 32'd7,  32'd9,  4'b1000);
      wait_idle(50);
      chk("tie_n_rsp", rl.size(), 2);
      if (rl.size() >= 2 && gl.size() >= 2) begin
         chk("tie_first_port",  rl[0].port, 0);
         chk("tie_first_res",   rl[0].res, 32'd30);
         chk("tie_second_port", rl[1].port, 1);
         chk("tie_second_res",  rl[1].res, 32'hFFFF_FFFE);
         chk("tie_second_flg",  rl[1].flg, 4'b0100);
         chk("tie_span",        rl[1].cyc - gl[0].cyc, 5);
      end

      // continuous contention: strict alternation
      gl.delete(); rl.delete();
      for (int i = 0; i < 4; i++) begin
         push(0, W'($urandom), W'($urandom), 4'b0110);
         push(1, W'($urandom), W'($urandom), 4'b0111);
      end
      wait_idle(100);
      chk("cont_n_grants", gl.size(), 8);
      for (int i = 0; i < gl.size() && i < 8; i++) chk("cont_grant_order", gl[i].port, i % 2);

      // back-pressure on port 0 while port 1 waits
      gl.delete(); rl.delete();
      rsp_mode[0] = 2;
      push(0, 32'd100, 32'd23, 4'b0000);
      push(1, 32'd1,   32'd2,  4'b0000);
      wait_rsp0(20);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid",  rsp0_valid,  1'b1);
         chk("bp_hold_result", rsp0_result, 32'd123);
         chk("bp_req1_ready",  req1_ready,  1'b0);
      end
      rsp_mode[0] = 0;
      wait_idle(50);
      if (rl.size() >= 2 && gl.size() >= 2) begin
         chk("bp_result",    rl[0].res, 32'd123);
         chk("bp_req1_port", gl[1].port, 1);
         chk("bp_req1_when", gl[1].cyc - rl[0].cyc, 1);
      end else begin
         chk("bp_n_events", rl.size(), 2);
      end

      // illegal op followed by a legal SLTU
      gl.delete(); rl.delete();
      push(0, 32'd1, 32'd1, 4'b0011);
      push(0, 32'd3, 32'd4, 4'b0010);
      wait_idle(50);
      chk("ill_n_rsp", rl.size(), 2);
      if (rl.size() >= 2) begin
         chk("ill_result",  rl[0].res, 32'd0);
         chk("ill_flags",   rl[0].flg, 4'b1010);
         chk("sltu_result", rl[1].res, 32'd1);
         chk("sltu_flags",  rl[1].flg, 4'b0000);
      end

      // reset while the response is pending
      rsp_mode[0] = 2;
      push(0, 32'd9, 32'd9, 4'b0000);
      wait_rsp0(20);
      #3 rst_n = 1'b0;
      req_q.delete();
      #1;
      chk("rst_mid_rsp0_valid", rsp0_valid, 1'b0);
      chk("rst_mid_rsp0_res",   rsp0_result, 32'd0);
      chk("rst_mid_alu_a",      alu_a, 32'd0);
      gl.delete(); rl.delete();
      repeat (2) @(posedge clk);
      rsp_mode[0] = 0;
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      chk("rst_mid_no_rsp", rl.size(), 0);
      push(1, 32'd2, 32'd2, 4'b0000);
      push(0, 32'd4, 32'd4, 4'b0000);
      wait_idle(50);
      if (gl.size() >= 1) chk("rst_mid_next_port", gl[0].port, 0);
      else                chk("rst_mid_n_grants", gl.size(), 2);

      // randomized traffic with gaps, withdrawals and random response back-pressure
      gl.delete(); rl.delete();
      gap_en = 1'b1; wd_en = 1'b1;
      rsp_mode[0] = 1; rsp_mode[1] = 1;
      for (int i = 0; i < 40; i++) begin
         push(0, W'($urandom), W'($urandom_range(0, 40)), 4'($urandom_range(0, 15)));
         push(1, W'($urandom), W'($urandom), 4'($urandom_range(0, 15)));
      end
      wait_idle(5000);
      chk("rand_n_rsp", rl.size(), 80);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
